// File: rtl/mem_bus_controller.sv
// Shared single-port memory controller. Arbitrates NumOfRequesters cores
// round-robin, runs one memory access at a time through IDLE/ISSUE/WAIT/RESP,
// and returns a one-cycle ACK (plus RDATA for reads) to the granted core.
module mem_bus_controller #(
  parameter int NumOfRequesters = 4,
  parameter int AddrWidth       = 8,
  parameter int DataWidth       = 32,
  parameter int MemLatency      = 2
) (
  input  logic                                 CLK,
  input  logic                                 RSTN,
  input  logic [NumOfRequesters-1:0]           REQ,
  input  logic [NumOfRequesters-1:0]           WE,
  input  logic [NumOfRequesters*AddrWidth-1:0] ADDR,
  input  logic [NumOfRequesters*DataWidth-1:0] WDATA,
  output logic [NumOfRequesters-1:0]           ACK,
  output logic [DataWidth-1:0]                 RDATA,
  output logic [$clog2(NumOfRequesters)-1:0]   GRANT_ID,
  output logic                                 BUSY,
  output logic                                 MEM_EN,
  output logic                                 MEM_WE,
  output logic [AddrWidth-1:0]                 MEM_ADDR,
  output logic [DataWidth-1:0]                 MEM_WDATA,
  input  logic [DataWidth-1:0]                 MEM_RDATA
);
  localparam int GW = $clog2(NumOfRequesters);
  localparam int CW = (MemLatency > 1) ? $clog2(MemLatency) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              wcnt_q, wcnt_d;
  logic [GW-1:0]              last_q, last_d;
  logic [GW-1:0]              gid_q, gid_d;
  logic                       we_q, we_d;
  logic [AddrWidth-1:0]       addr_q, addr_d;
  logic [DataWidth-1:0]       wdata_q, wdata_d;
  logic                       en_q, en_d;
  logic [NumOfRequesters-1:0] ack_q, ack_d;
  logic [DataWidth-1:0]       rdata_q, rdata_d;
  logic                       busy_q, busy_d;

  logic                       win_found;
  logic [GW-1:0]              win_id;
  logic [GW:0]                cand;

  // Round-robin pick: first requester at or after last_grant+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= NumOfRequesters; i++) begin
      cand = {1'b0, last_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NumOfRequesters)) cand = cand - (GW+1)'(NumOfRequesters);
      if (!win_found && REQ[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[GW-1:0];
      end
    end
  end

  // Next-state and registered-output values; outputs are derived from the
  // state being entered so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (win_found) begin
        state_d = ISSUE;
        gid_d   = win_id;
        we_d    = WE[win_id];
        addr_d  = ADDR[win_id*AddrWidth +: AddrWidth];
        wdata_d = WDATA[win_id*DataWidth +: DataWidth];
      end
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: if (wcnt_q == CW'(MemLatency-1)) begin
        state_d = RESP;
        if (!we_q) rdata_d = MEM_RDATA;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = gid_q;
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
    ack_d  = '0;
    if (state_d == RESP) ack_d[gid_q] = 1'b1;
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      last_q  <= GW'(NumOfRequesters-1);
      gid_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign GRANT_ID  = gid_q;
  assign BUSY      = busy_q;
  assign MEM_EN    = en_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: directed transactions, a behavioural memory,
// and a scoreboard whose monitor checks every ACK pulse against the queue.
module tb_mem_bus_controller;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int ML = 2;

  logic            CLK, RSTN;
  logic [N-1:0]    REQ, WE, ACK;
  logic [N*AW-1:0] ADDR;
  logic [N*DW-1:0] WDATA;
  logic [DW-1:0]   RDATA, MEM_WDATA, MEM_RDATA;
  logic [1:0]      GRANT_ID;
  logic            BUSY, MEM_EN, MEM_WE;
  logic [AW-1:0]   MEM_ADDR;

  mem_bus_controller #(.NumOfRequesters(N), .AddrWidth(AW), .DataWidth(DW),
                       .MemLatency(ML)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: unwritten locations return a fixed pattern per address.
  logic [DW-1:0] mem [256];
  logic [255:0]  wr_v;
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h30:   return 32'hCAFE0033;
      default: return 32'h0000_0100 + {24'h0, a};
    endcase
  endfunction
  initial wr_v = '0;
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) begin
        mem[MEM_ADDR]  <= MEM_WDATA;
        wr_v[MEM_ADDR] <= 1'b1;
      end else begin
        MEM_RDATA <= wr_v[MEM_ADDR] ? mem[MEM_ADDR] : init_val(MEM_ADDR);
      end
    end
  end

  typedef struct {int id; logic [DW-1:0] data; int gap;} exp_t;
  exp_t q[$];

  int s_chk = 0, s_fail = 0, m_chk = 0, m_fail = 0;

  task automatic schk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    s_chk++;
    if (act !== exp) begin
      s_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mchk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    m_chk++;
    if (act !== exp) begin
      m_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ACK pulse is matched against the oldest expectation.
  initial begin
    int   cyc, last_ack;
    exp_t e;
    cyc = 0;
    last_ack = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ACK !== '0) begin
        if (q.size() == 0) begin
          m_chk++;
          m_fail++;
          $display("FAIL unexpected_ack: got %b expected none", ACK);
        end else begin
          e = q.pop_front();
          mchk("ack_vec", 32'(ACK), 32'(1 << e.id));
          mchk("grant_id", 32'(GRANT_ID), 32'(e.id));
          mchk("rdata", RDATA, e.data);
          if (e.gap != 0) mchk("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
        end
        last_ack = cyc;
      end
    end
  end

  function automatic exp_t mk(input int id, input logic [DW-1:0] d, input int gap);
    exp_t e;
    e.id = id; e.data = d; e.gap = gap;
    return e;
  endfunction

  // Waits for core id's ACK, then drops its REQ (cores hold REQ until ACK).
  task automatic wait_ack(input int id, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      lat++;
      if (ACK[id] === 1'b1) begin
        REQ[id] = 1'b0;
        seen = 1;
      end
    end
    if (!seen) begin
      s_chk++;
      s_fail++;
      $display("FAIL ack_timeout: core %0d got no ACK expected one within 40 cycles", id);
    end
  endtask

  initial begin
    int lat;
    RSTN = 1'b0; REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    repeat (2) @(negedge CLK);
    schk("rst_ack", 32'(ACK), 0);
    schk("rst_busy", 32'(BUSY), 0);
    schk("rst_mem_en", 32'(MEM_EN), 0);
    schk("rst_grant_id", 32'(GRANT_ID), 0);
    schk("rst_rdata", RDATA, 0);
    schk("rst_mem_addr", 32'(MEM_ADDR), 0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Core 1 read of 0x10: MEM_EN for exactly one cycle, ACK four cycles after grant.
    ADDR[1*AW +: AW] = 8'h10;
    q.push_back(mk(1, 32'hDEADBEEF, 0));
    REQ = 4'b0010;
    @(negedge CLK);
    schk("t29_mem_en_issue", 32'(MEM_EN), 1);
    schk("t29_mem_addr", 32'(MEM_ADDR), 32'h10);
    schk("t29_busy", 32'(BUSY), 1);
    @(negedge CLK);
    schk("t29_mem_en_wait", 32'(MEM_EN), 0);
    wait_ack(1, lat);
    schk("t29_ack_latency", 32'(lat + 2), 4);
    @(negedge CLK);
    schk("t29_idle_ack", 32'(ACK), 0);

    // All four cores requesting from reset: 0,1,2,3,0 spaced five cycles.
    RSTN = 1'b0;
    REQ  = 4'b1111;
    for (int i = 0; i < N; i++) ADDR[i*AW +: AW] = AW'(i);
    q.push_back(mk(0, 32'h100, 0));
    q.push_back(mk(1, 32'h101, 5));
    q.push_back(mk(2, 32'h102, 5));
    q.push_back(mk(3, 32'h103, 5));
    q.push_back(mk(0, 32'h100, 5));
    @(negedge CLK);
    RSTN = 1'b1;
    for (int n = 0; n < 5; n++) begin
      int c;
      c = 0;
      do begin @(negedge CLK); c++; end while (ACK === '0 && c < 40);
      if (c >= 40) schk("t30_ack_timeout", 32'(c), 0);
    end
    REQ = '0;
    repeat (2) @(negedge CLK);

    // After a grant to core 2, cores 3 and 0 contend: 3 comes first.
    q.push_back(mk(2, 32'h102, 0));
    q.push_back(mk(3, 32'h103, 0));
    q.push_back(mk(0, 32'h100, 0));
    REQ = 4'b0100;
    wait_ack(2, lat);
    REQ = REQ | 4'b1001;
    wait_ack(3, lat);
    wait_ack(0, lat);
    repeat (2) @(negedge CLK);

    // Reset during WAIT: everything drops at once and no ACK ever appears.
    REQ = 4'b0010;
    repeat (2) @(negedge CLK);
    schk("t32_busy_in_wait", 32'(BUSY), 1);
    REQ  = '0;
    RSTN = 1'b0;
    #1;
    schk("t32_busy_rst", 32'(BUSY), 0);
    schk("t32_mem_en_rst", 32'(MEM_EN), 0);
    schk("t32_ack_rst", 32'(ACK), 0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (8) @(negedge CLK);
    schk("t32_idle_busy", 32'(BUSY), 0);

    // Core 0 drops REQ and changes ADDR mid-transaction; access still completes.
    ADDR[0 +: AW] = 8'h30;
    q.push_back(mk(0, 32'hCAFE0033, 0));
    REQ = 4'b0001;
    @(negedge CLK);
    schk("t33_mem_addr_issue", 32'(MEM_ADDR), 32'h30);
    @(negedge CLK);
    REQ = '0;
    ADDR[0 +: AW] = 8'h77;
    WE[0] = 1'b1;
    @(negedge CLK);
    schk("t33_mem_addr_hold", 32'(MEM_ADDR), 32'h30);
    schk("t33_mem_we_hold", 32'(MEM_WE), 0);
    wait_ack(0, lat);
    WE[0] = 1'b0;
    repeat (2) @(negedge CLK);

    // Core 3 write then read-back of 0x20; the write leaves RDATA alone.
    WE[3] = 1'b1;
    ADDR[3*AW +: AW] = 8'h20;
    WDATA[3*DW +: DW] = 32'h5A5A5A5A;
    q.push_back(mk(3, 32'hCAFE0033, 0));
    REQ = 4'b1000;
    @(negedge CLK);
    schk("t34_mem_we", 32'(MEM_WE), 1);
    schk("t34_mem_addr", 32'(MEM_ADDR), 32'h20);
    schk("t34_mem_wdata", MEM_WDATA, 32'h5A5A5A5A);
    wait_ack(3, lat);
    WE[3] = 1'b0;
    q.push_back(mk(3, 32'h5A5A5A5A, 0));
    REQ = 4'b1000;
    @(negedge CLK);
    @(negedge CLK);
    schk("t34_mem_we_read", 32'(MEM_WE), 0);
    wait_ack(3, lat);
    repeat (4) @(negedge CLK);

    schk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             s_chk + m_chk, s_fail + m_fail);
    $finish;
  end
endmodule
